// File: rtl/spi_fsm_pkg.sv
// Shared types and default constants for the SPI video front-end.
`timescale 1ns/1ps
package spi_fsm_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INIT_WAIT,
      PAUSE,
      PAUSE_DONE,
      STREAM,
      FILL
   } state_t;

   localparam int DEF_SYNC_STAGES           = 2;
   localparam int DEF_INIT_DELAY_CYCLES     = 1000;
   localparam int DEF_MODE_SWITCH_THRESHOLD = 48;
   localparam int DEF_FILL_CYCLES           = 64;

endpackage

// File: rtl/spi_fsm_top_cdc.sv
// Synchroniser chain plus history flop; emits an aligned level and a registered rise pulse.
`timescale 1ns/1ps
module cdc_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic async_sig,
   output logic level,
   output logic rise
);

   logic [SYNC_STAGES-1:0] chain_reg;
   logic                   hist_reg;
   logic                   rise_reg;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
               if (reset) chain_reg[0] <= 1'b0;
               else       chain_reg[0] <= async_sig;
            end
         end else begin : g_next
            always_ff @(posedge clk) begin
               if (reset) chain_reg[gi] <= 1'b0;
               else       chain_reg[gi] <= chain_reg[gi-1];
            end
         end
      end
   endgenerate

   // Level is taken from the history flop so it lines up with the registered pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         hist_reg <= 1'b0;
         rise_reg <= 1'b0;
      end else begin
         hist_reg <= chain_reg[SYNC_STAGES-1];
         rise_reg <= chain_reg[SYNC_STAGES-1] & ~hist_reg;
      end
   end

   assign level = hist_reg;
   assign rise  = rise_reg;

endmodule

// File: rtl/spi_fsm_top.sv
// SPI video front-end: CDC of SPI/data clocks and MISO, plus the idle/init/pause/stream/fill FSM.
`timescale 1ns/1ps
module spi_fsm_top
   import spi_fsm_pkg::*;
#(
   parameter int SYNC_STAGES           = DEF_SYNC_STAGES,
   parameter int INIT_DELAY_CYCLES     = DEF_INIT_DELAY_CYCLES,
   parameter int MODE_SWITCH_THRESHOLD = DEF_MODE_SWITCH_THRESHOLD,
   parameter int FILL_CYCLES           = DEF_FILL_CYCLES
) (
   input  logic CLK_40,
   input  logic reset,
   input  logic init,
   input  logic vid_start,
   input  logic MISO_CDC,
   input  logic SPI_clk_CDC,
   input  logic data_write_clk_CDC,
   output logic received_bit,
   output logic video_data_ready,
   output logic SPI_clk_rising_edge,
   output logic data_clk_rising_edge,
   output logic chip_select
);

   localparam int INIT_W = $clog2(INIT_DELAY_CYCLES + 1);
   localparam int BIT_W  = $clog2(MODE_SWITCH_THRESHOLD + 1);
   localparam int FILL_W = $clog2(FILL_CYCLES + 1);

   logic spi_rise, data_rise, miso_level;
   logic spi_level_unused, data_level_unused, miso_rise_unused;
   logic received_bit_reg;

   state_t              state_reg, state_next;
   logic [INIT_W-1:0]   init_cnt_reg, init_cnt_next;
   logic [BIT_W-1:0]    bit_cnt_reg, bit_cnt_next;
   logic [FILL_W-1:0]   fill_cnt_reg, fill_cnt_next;
   logic                pause_en, pause_done, switch_mode;

   cdc_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_spi_clk (
      .clk(CLK_40), .reset(reset), .async_sig(SPI_clk_CDC),
      .level(spi_level_unused), .rise(spi_rise)
   );
   cdc_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_data_clk (
      .clk(CLK_40), .reset(reset), .async_sig(data_write_clk_CDC),
      .level(data_level_unused), .rise(data_rise)
   );
   cdc_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_miso (
      .clk(CLK_40), .reset(reset), .async_sig(MISO_CDC),
      .level(miso_level), .rise(miso_rise_unused)
   );

   assign SPI_clk_rising_edge  = spi_rise;
   assign data_clk_rising_edge = data_rise;
   assign received_bit         = received_bit_reg;

   always_ff @(posedge CLK_40) begin
      if (reset) begin
         received_bit_reg <= 1'b0;
         state_reg        <= IDLE;
         init_cnt_reg     <= '0;
         bit_cnt_reg      <= '0;
         fill_cnt_reg     <= '0;
      end else begin
         if (spi_rise) received_bit_reg <= miso_level;
         state_reg    <= state_next;
         init_cnt_reg <= init_cnt_next;
         bit_cnt_reg  <= bit_cnt_next;
         fill_cnt_reg <= fill_cnt_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      init_cnt_next    = init_cnt_reg;
      bit_cnt_next     = bit_cnt_reg;
      fill_cnt_next    = fill_cnt_reg;
      pause_en         = 1'b0;
      pause_done       = 1'b0;
      switch_mode      = 1'b0;
      video_data_ready = 1'b0;
      chip_select      = 1'b1;
      case (state_reg)
         IDLE: begin
            if (init) begin
               state_next    = INIT_WAIT;
               init_cnt_next = '0;
            end
         end
         INIT_WAIT: begin
            if (init_cnt_reg == INIT_W'(INIT_DELAY_CYCLES - 1)) state_next = PAUSE;
            else init_cnt_next = init_cnt_reg + 1'b1;
         end
         PAUSE: begin
            pause_en = 1'b1;
            if (vid_start) state_next = PAUSE_DONE;
         end
         PAUSE_DONE: begin
            pause_done   = 1'b1;
            state_next   = STREAM;
            bit_cnt_next = '0;
         end
         STREAM: begin
            video_data_ready = 1'b1;
            chip_select      = 1'b0;
            // Written so an unknown vid_start falls into the PAUSE branch.
            if (vid_start) begin
               if (spi_rise) begin
                  bit_cnt_next = bit_cnt_reg + 1'b1;
                  if (bit_cnt_reg == BIT_W'(MODE_SWITCH_THRESHOLD - 1)) begin
                     state_next    = FILL;
                     switch_mode   = 1'b1;
                     fill_cnt_next = '0;
                  end
               end
            end else begin
               state_next = PAUSE;
            end
         end
         FILL: begin
            if (fill_cnt_reg == FILL_W'(FILL_CYCLES - 1)) begin
               if (vid_start) begin
                  state_next   = STREAM;
                  bit_cnt_next = '0;
               end else begin
                  state_next = PAUSE;
               end
            end else begin
               fill_cnt_next = fill_cnt_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_spi_fsm_top.sv
// Scoreboard bench for spi_fsm_top: sent SPI bits are queued, a monitor checks each strobed sample.
`timescale 1ns/1ps
module tb_spi_fsm_top;
   import spi_fsm_pkg::*;

   logic CLK_40 = 1'b0;
   logic reset = 1'b1, init = 1'b0, vid_start = 1'b0;
   logic MISO_CDC = 1'b0, SPI_clk_CDC = 1'b0, data_write_clk_CDC = 1'b0;
   logic received_bit, video_data_ready, SPI_clk_rising_edge, data_clk_rising_edge, chip_select;

   int tests = 0, fails = 0, cyc = 0;
   int spi_total = 0, data_total = 0, data_double = 0, switch_total = 0;
   int fill_total = 0, fill_bad = 0;
   logic exp_q[$];

   spi_fsm_top dut (
      .CLK_40(CLK_40), .reset(reset), .init(init), .vid_start(vid_start),
      .MISO_CDC(MISO_CDC), .SPI_clk_CDC(SPI_clk_CDC), .data_write_clk_CDC(data_write_clk_CDC),
      .received_bit(received_bit), .video_data_ready(video_data_ready),
      .SPI_clk_rising_edge(SPI_clk_rising_edge), .data_clk_rising_edge(data_clk_rising_edge),
      .chip_select(chip_select)
   );

   always #12.5 CLK_40 = ~CLK_40;
   always @(posedge CLK_40) cyc <= cyc + 1;

   initial begin
      #137;
      forever begin
         data_write_clk_CDC = ~data_write_clk_CDC;
         #500;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end else begin
         $display("[TB] ok %s = %0h", name, act);
      end
   endtask

   // Monitor: the cycle after each SPI strobe, received_bit must equal the oldest queued bit.
   initial begin
      logic pending, data_prev;
      pending   = 1'b0;
      data_prev = 1'b0;
      forever begin
         @(negedge CLK_40);
         if (pending) begin
            if (exp_q.size() == 0) check("spi_bits_pending", 32'(exp_q.size()), 1);
            else check("received_bit", received_bit, exp_q.pop_front());
         end
         pending = (SPI_clk_rising_edge === 1'b1);
         if (SPI_clk_rising_edge === 1'b1) spi_total++;
         if (data_clk_rising_edge === 1'b1) begin
            data_total++;
            if (data_prev) data_double++;
         end
         data_prev = (data_clk_rising_edge === 1'b1);
         if (dut.switch_mode === 1'b1) switch_total++;
         if (dut.state_reg == FILL) begin
            fill_total++;
            if (chip_select !== 1'b1 || video_data_ready !== 1'b0) fill_bad++;
         end
      end
   end

   task automatic send_bit(input logic b);
      int lo, hi;
      lo = $urandom_range(420, 580);
      hi = $urandom_range(420, 580);
      MISO_CDC = b;
      #(lo);
      exp_q.push_back(b);
      SPI_clk_CDC = 1'b1;
      #(hi);
      SPI_clk_CDC = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_received_bit"}, received_bit, 1'b0);
      check({tag, "_ready"}, video_data_ready, 1'b0);
      check({tag, "_cs"}, chip_select, 1'b1);
      check({tag, "_spi_strobe"}, SPI_clk_rising_edge, 1'b0);
      check({tag, "_data_strobe"}, data_clk_rising_edge, 1'b0);
      check({tag, "_state"}, dut.state_reg, IDLE);
   endtask

   initial begin
      logic [7:0] stream_bytes [6];
      int c0, waited, width, s0, w0, f0, b0, d0, dd0;
      stream_bytes = '{8'h00, 8'h00, 8'hFF, 8'hBB, 8'hA0, 8'hD2};

      // Reset pulses of 1 us, 2 us, then 50 us held with SPI activity that must be ignored.
      reset = 1'b1;
      repeat (40) @(negedge CLK_40);
      check_reset("reset1us");
      reset = 1'b0;
      repeat (20) @(negedge CLK_40);
      reset = 1'b1;
      repeat (80) @(negedge CLK_40);
      check_reset("reset2us");
      reset = 1'b0;
      repeat (20) @(negedge CLK_40);
      reset = 1'b1;
      s0 = spi_total;
      repeat (20) begin
         SPI_clk_CDC = 1'b1; #500;
         SPI_clk_CDC = 1'b0; #500;
      end
      repeat (1200) @(negedge CLK_40);
      check("reset_hold_spi_strobes", spi_total - s0, 0);
      check_reset("reset50us");
      reset = 1'b0;
      repeat (10) @(negedge CLK_40);

      // init for 2 us: pause_en must appear exactly 1000 cycles after the sampling edge.
      @(posedge CLK_40);
      #1;
      init = 1'b1;
      c0 = cyc;
      waited = 0;
      while (dut.pause_en !== 1'b1 && waited < 3000) begin
         @(negedge CLK_40);
         waited++;
         if (waited == 80) init = 1'b0;
      end
      check("pause_en_delay", cyc - c0 - 1, 1000);
      check("state_pause", dut.state_reg, PAUSE);
      check("pause_cs", chip_select, 1'b1);
      repeat (20) @(negedge CLK_40);
      check("pause_en_hold", dut.pause_en, 1'b1);

      // vid_start: single-cycle pause_done, then streaming outputs.
      vid_start = 1'b1;
      waited = 0;
      while (dut.pause_done !== 1'b1 && waited < 20) begin
         @(negedge CLK_40);
         waited++;
      end
      check("pause_done_seen", dut.pause_done, 1'b1);
      width = 0;
      while (dut.pause_done === 1'b1 && width < 20) begin
         width++;
         @(negedge CLK_40);
      end
      check("pause_done_width", width, 1);
      check("stream_state", dut.state_reg, STREAM);
      check("stream_cs", chip_select, 1'b0);
      check("stream_ready", video_data_ready, 1'b1);

      // 48 bits: the last edge reaches the threshold and starts a 64-cycle FILL.
      s0 = spi_total; w0 = switch_total; f0 = fill_total; b0 = fill_bad;
      for (int k = 0; k < 6; k++) send_byte(stream_bytes[k]);
      waited = 0;
      while (dut.state_reg != STREAM && waited < 400) begin
         @(negedge CLK_40);
         waited++;
      end
      repeat (2) @(negedge CLK_40);
      check("stream_spi_edges", spi_total - s0, 48);
      check("switch_mode_pulses", switch_total - w0, 1);
      check("fill_cycles", fill_total - f0, 64);
      check("fill_outputs_bad", fill_bad - b0, 0);
      check("refill_state", dut.state_reg, STREAM);
      check("refill_ready", video_data_ready, 1'b1);
      check("refill_cs", chip_select, 1'b0);
      check("refill_bit_cnt", 32'(dut.bit_cnt_reg), 0);

      // vid_start low returns to PAUSE; strobes and received_bit keep working there.
      vid_start = 1'b0;
      repeat (3) @(negedge CLK_40);
      check("back_pause_state", dut.state_reg, PAUSE);
      check("back_pause_en", dut.pause_en, 1'b1);
      check("back_pause_cs", chip_select, 1'b1);
      check("back_pause_ready", video_data_ready, 1'b0);
      send_bit(1'b1);
      repeat (10) @(negedge CLK_40);

      // 250 us with the SPI clock idle low.
      s0 = spi_total; d0 = data_total; dd0 = data_double;
      repeat (10000) @(negedge CLK_40);
      check("idle_spi_strobes", spi_total - s0, 0);
      check("idle_received_bit_hold", received_bit, 1'b1);
      check("idle_data_edges_in_249_251", (data_total - d0 >= 249) && (data_total - d0 <= 251), 1'b1);
      check("data_strobe_stretched", data_double - dd0, 0);
      check("scoreboard_drained", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
